// File: rtl/if_id_stage.sv
// if_id_stage: fetch stage with PC, redirect/stall handling and IF/ID register
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        EX_Branch_taken,
  input  logic [31:0] EX_Branch_target,
  input  logic        EX_Jump,
  input  logic [25:0] EX_Jump_ins_add,
  input  logic [31:0] EX_PC,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instr,
  output logic        ID_valid,
  output logic [4:0]  ID_rs,
  output logic [4:0]  ID_rt,
  output logic [4:0]  ID_rd,
  output logic [25:0] ID_Jump_ins_add,
  output logic [15:0] ID_Imm16,
  output logic        IDEX_flush,
  output logic [31:0] fetch_count
);
  logic [31:0] pc, pc_next, target;
  logic        redirect;
  always_comb begin
    redirect = EX_Jump | EX_Branch_taken;
    pc_next  = pc + 32'(PC_STEP);
    target   = EX_Jump ? {EX_PC[31:28], EX_Jump_ins_add, 2'b00} : {EX_Branch_target[31:2], 2'b00};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ID_PC       <= '0;
      ID_Instr    <= '0;
      ID_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc       <= target;
      ID_PC    <= '0;
      ID_Instr <= '0;
      ID_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_next;
      ID_PC       <= pc_next;
      ID_Instr    <= imem_rdata;
      ID_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end
  assign imem_addr       = pc;
  assign IDEX_flush      = redirect;
  assign ID_rs           = ID_Instr[25:21];
  assign ID_rt           = ID_Instr[20:16];
  assign ID_rd           = ID_Instr[15:11];
  assign ID_Jump_ins_add = ID_Instr[25:0];
  assign ID_Imm16        = ID_Instr[15:0];
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed checks of fetch, stall, redirect, wrap and async reset
module tb_if_id_stage;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        EX_Branch_taken = 1'b0, EX_Jump = 1'b0;
  logic [31:0] EX_Branch_target = '0, EX_PC = '0;
  logic [25:0] EX_Jump_ins_add = '0;
  logic [31:0] imem_addr, imem_rdata, ID_PC, ID_Instr, fetch_count;
  logic        ID_valid, IDEX_flush;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic [25:0] ID_Jump_ins_add;
  logic [15:0] ID_Imm16;
  int n_cmp = 0, n_bad = 0;
  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .EX_Branch_taken(EX_Branch_taken), .EX_Branch_target(EX_Branch_target),
    .EX_Jump(EX_Jump), .EX_Jump_ins_add(EX_Jump_ins_add), .EX_PC(EX_PC),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ID_PC(ID_PC), .ID_Instr(ID_Instr), .ID_valid(ID_valid),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_Jump_ins_add(ID_Jump_ins_add), .ID_Imm16(ID_Imm16),
    .IDEX_flush(IDEX_flush), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr | 32'h1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic id_chk(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] idpc, input logic v, input logic [31:0] cnt);
    chk({tag, ".pc"}, imem_addr, pc);
    chk({tag, ".instr"}, ID_Instr, ins);
    chk({tag, ".idpc"}, ID_PC, idpc);
    chk({tag, ".valid"}, 32'(ID_valid), 32'(v));
    chk({tag, ".cnt"}, fetch_count, cnt);
  endtask
  initial begin
    #2;
    id_chk("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    // sequential fetch
    step(); id_chk("run1", 32'h4, 32'h1, 32'h4, 1'b1, 32'd1);
    step(); id_chk("run2", 32'h8, 32'h5, 32'h8, 1'b1, 32'd2);
    step(); id_chk("run3", 32'hC, 32'h9, 32'hC, 1'b1, 32'd3);
    step(); id_chk("run4", 32'h10, 32'hD, 32'h10, 1'b1, 32'd4);
    chk("flds.rs", 32'(ID_rs), 32'h0);
    chk("flds.imm", 32'(ID_Imm16), 32'hD);
    // load-use stall holds everything
    stall = 1'b1;
    #1 chk("stall.flush", 32'(IDEX_flush), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); id_chk($sformatf("stall%0d", i), 32'h10, 32'hD, 32'h10, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step(); id_chk("release", 32'h14, 32'h11, 32'h14, 1'b1, 32'd5);
    // taken branch, low bits of target forced to zero
    EX_Branch_taken = 1'b1; EX_Branch_target = 32'h0000_0103;
    #1 chk("br.flush", 32'(IDEX_flush), 32'h1);
    step(); id_chk("br", 32'h100, 32'h0, 32'h0, 1'b0, 32'd5);
    EX_Branch_taken = 1'b0;
    #1 chk("br.flush0", 32'(IDEX_flush), 32'h0);
    // jump
    EX_Jump = 1'b1; EX_PC = 32'h3000_0010; EX_Jump_ins_add = 26'h040;
    step(); id_chk("jmp", 32'h3000_0100, 32'h0, 32'h0, 1'b0, 32'd5);
    EX_Jump = 1'b0;
    step(); id_chk("jmp.adv", 32'h3000_0104, 32'h3000_0101, 32'h3000_0104, 1'b1, 32'd6);
    chk("jmp.rt", 32'(ID_rt), 32'h0);
    chk("jmp.jia", 32'(ID_Jump_ins_add), 32'h101);
    // jump beats branch, redirect beats stall
    EX_Jump = 1'b1; EX_Branch_taken = 1'b1; stall = 1'b1;
    EX_PC = 32'h5000_0000; EX_Jump_ins_add = 26'h200; EX_Branch_target = 32'h700;
    #1 chk("both.flush", 32'(IDEX_flush), 32'h1);
    step(); id_chk("both", 32'h5000_0800, 32'h0, 32'h0, 1'b0, 32'd6);
    EX_Branch_taken = 1'b0; stall = 1'b0;
    // PC wrap
    EX_PC = 32'hF000_0000; EX_Jump_ins_add = 26'h3FF_FFFF;
    step(); chk("wrap.top", imem_addr, 32'hFFFF_FFFC);
    EX_Jump = 1'b0;
    step(); id_chk("wrap", 32'h0, 32'hFFFF_FFFD, 32'h0, 1'b1, 32'd7);
    chk("wrap.rd", 32'(ID_rd), 32'h1F);
    step(); id_chk("wrap2", 32'h4, 32'h1, 32'h4, 1'b1, 32'd8);
    // async reset between edges
    #2 rst = 1'b1;
    #1 id_chk("arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(); rst = 1'b0;
    #1 chk("arst.hold", imem_addr, 32'h0);
    step(); id_chk("resume", 32'h4, 32'h1, 32'h4, 1'b1, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
